// File: rtl/fill_pkg.sv
// Shared types and sizing for the polygon fill sequencer.
package fill_pkg;

  localparam int NUM_ROWS       = 64;
  localparam int ROW_W          = 7;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int WDOG_W         = 8;

  localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATH,
    S_READ,
    S_WAIT_WR,
    S_FILL,
    S_ADV,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/fill_sequencer.sv
// Fill control FSM: min-corner math, then per-row read / wait-write / fill / advance; Moore outputs.
// Optional handshake watchdog enabled by defining FILL_TIMEOUT_EN.
module fill_sequencer
  import fill_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             abort,
  output logic             math_start,
  input  logic             math_done,
  output logic             row_start,
  input  logic             rd_valid,
  input  logic             wr_ready,
  output logic             fill_start,
  input  logic             fill_done,
  input  logic             all_finish,
  output logic [ROW_W-1:0] row_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  fill_state_t      state, state_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [ROW_W-1:0] row_inc;
  logic             last_row;
  logic             err_nxt;
  logic             err_q;
  logic             timeout;

  // Counter holds at NUM_ROWS rather than wrapping
  assign row_inc  = (row_idx >= ROWS_L) ? row_idx : row_idx + ROW_W'(1);
  assign last_row = (row_inc == ROWS_L);

`ifdef FILL_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
  logic              wait_st;

  assign wait_st = (state == S_MATH) || (state == S_READ) || (state == S_WAIT_WR);
  assign timeout = wait_st && (wdog == WDOG_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog <= '0;
    end else if (!wait_st || (state_nxt != state)) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WDOG_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_MATH;
          row_nxt   = '0;
        end
      end
      S_MATH:    if (math_done) state_nxt = S_READ;
      S_READ:    if (rd_valid)  state_nxt = S_WAIT_WR;
      S_WAIT_WR: if (wr_ready)  state_nxt = S_FILL;
      S_FILL: begin
        if (fill_done) begin
          state_nxt = S_ADV;
        end else begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_ADV: begin
        row_nxt = row_inc;
        if (last_row || all_finish) begin
          state_nxt = S_DONE;
          err_nxt   = last_row ^ all_finish;
        end else begin
          state_nxt = S_READ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
    // Abort overrides any handshake completing in the same cycle
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      row_nxt   = row_idx;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      row_idx <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      err_q   <= err_nxt;
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign math_start = (state == S_MATH);
  assign row_start  = (state == S_READ);
  assign fill_start = (state == S_FILL);
  assign done       = (state == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer: per-cycle vector table plus full-fill and corner-case sequences.
module tb_fill_sequencer;
  import fill_pkg::*;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             cmd_valid, cmd_ready, abort;
  logic             math_start, math_done, row_start, rd_valid, wr_ready;
  logic             fill_start, fill_done, all_finish;
  logic [ROW_W-1:0] row_idx;
  logic             busy, done, err;

  always #5 clk = ~clk;

  fill_sequencer dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .math_start(math_start), .math_done(math_done), .row_start(row_start), .rd_valid(rd_valid),
    .wr_ready(wr_ready), .fill_start(fill_start), .fill_done(fill_done), .all_finish(all_finish),
    .row_idx(row_idx), .busy(busy), .done(done), .err(err)
  );

  // fill_block / SRAM stand-in; auto_m=0 hands the inputs to the vector table
  logic auto_m, wr_stuck, fd_fault;
  logic v_md, v_rv, v_wr, v_fd, v_af;
  int   rd_delay, rd_cnt, fill_cnt;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_cnt   <= 0;
      fill_cnt <= 0;
    end else begin
      rd_cnt <= row_start ? rd_cnt + 1 : 0;
      if (math_start) fill_cnt <= 0;
      else if (fill_start) fill_cnt <= fill_cnt + 1;
    end
  end

  assign math_done  = auto_m ? math_start : v_md;
  assign rd_valid   = auto_m ? (row_start && (rd_cnt >= rd_delay)) : v_rv;
  assign wr_ready   = auto_m ? !wr_stuck : v_wr;
  assign fill_done  = auto_m ? (fill_start && !(fd_fault && (fill_cnt == 3))) : v_fd;
  assign all_finish = auto_m ? (fill_cnt >= NUM_ROWS) : v_af;

  logic clr_mon, prev_fs;
  int   done_cnt, err_cnt, fs_cnt, fs_bad, rs_run, rs_n, rs_bad;

  always @(negedge clk) begin
    if (clr_mon) begin
      done_cnt <= 0; err_cnt <= 0; fs_cnt <= 0; fs_bad <= 0;
      rs_run <= 0; rs_n <= 0; rs_bad <= 0; prev_fs <= 1'b0;
    end else begin
      prev_fs <= fill_start;
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
      if (fill_start) begin
        fs_cnt <= fs_cnt + 1;
        if (prev_fs) fs_bad <= fs_bad + 1;
      end
      if (row_start) begin
        rs_run <= rs_run + 1;
      end else if (rs_run != 0) begin
        rs_n <= rs_n + 1;
        if (rs_run != rd_delay + 1) rs_bad <= rs_bad + 1;
        rs_run <= 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {cmd_ready, math_start, row_start, fill_start, busy, done, err};
  endfunction

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk); #1;
    clr_mon = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue a command, count edges until done (edge accepting the command is edge 1)
  task automatic run_to_done(input int budget, output int k, output logic got);
    k = 0; got = 1'b0;
    cmd_valid = 1'b1;
    while (!got && k < budget) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k++;
      if (done) got = 1'b1;
    end
  endtask

  // inputs {cmd_valid, abort, math_done, rd_valid, wr_ready, fill_done, all_finish}
  // outputs {cmd_ready, math_start, row_start, fill_start, busy, done, err}
  typedef struct {
    logic [6:0]       in_v;
    logic [6:0]       exp_o;
    logic [ROW_W-1:0] exp_row;
  } vec_t;

  vec_t vecs[27];

  initial begin
    int   k;
    logic got;
    logic [6:0] iv;

    vecs[0]  = '{7'b1000000, 7'b0100100, 7'd0};  // accept -> MATH
    vecs[1]  = '{7'b0000000, 7'b0100100, 7'd0};  // wait math_done
    vecs[2]  = '{7'b0010000, 7'b0010100, 7'd0};  // READ
    vecs[3]  = '{7'b0000000, 7'b0010100, 7'd0};  // row_start held
    vecs[4]  = '{7'b0001000, 7'b0000100, 7'd0};  // WAIT_WR
    vecs[5]  = '{7'b0000000, 7'b0000100, 7'd0};
    vecs[6]  = '{7'b0000100, 7'b0001100, 7'd0};  // FILL
    vecs[7]  = '{7'b0000010, 7'b0000100, 7'd0};  // ADV
    vecs[8]  = '{7'b0000000, 7'b0010100, 7'd1};  // READ row 1
    vecs[9]  = '{7'b1000000, 7'b0010100, 7'd1};  // cmd while busy ignored
    vecs[10] = '{7'b0101000, 7'b1000000, 7'd1};  // abort beats rd_valid
    vecs[11] = '{7'b0000000, 7'b1000000, 7'd1};
    vecs[12] = '{7'b1000000, 7'b0100100, 7'd0};
    vecs[13] = '{7'b0010000, 7'b0010100, 7'd0};
    vecs[14] = '{7'b0001000, 7'b0000100, 7'd0};
    vecs[15] = '{7'b0000100, 7'b0001100, 7'd0};
    vecs[16] = '{7'b0000000, 7'b1000001, 7'd0};  // fill_done low -> err, IDLE
    vecs[17] = '{7'b0000000, 7'b1000000, 7'd0};
    vecs[18] = '{7'b1000000, 7'b0100100, 7'd0};
    vecs[19] = '{7'b0010000, 7'b0010100, 7'd0};
    vecs[20] = '{7'b0001000, 7'b0000100, 7'd0};
    vecs[21] = '{7'b0000100, 7'b0001100, 7'd0};
    vecs[22] = '{7'b0000010, 7'b0000100, 7'd0};
    vecs[23] = '{7'b0000001, 7'b0000111, 7'd1};  // early all_finish -> DONE + err
    vecs[24] = '{7'b0000000, 7'b1000000, 7'd1};
    vecs[25] = '{7'b1000000, 7'b0100100, 7'd0};
    vecs[26] = '{7'b0110000, 7'b1000000, 7'd0};  // abort beats math_done

    n_rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    auto_m = 1'b0; wr_stuck = 1'b0; fd_fault = 1'b0; rd_delay = 0;
    {v_md, v_rv, v_wr, v_fd, v_af} = '0;
    clr_mon = 1'b1;
    #1;
    chk("reset_outs", int'(outs()), int'(7'b1000000));
    chk("reset_row", int'(row_idx), 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    clr_mon = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 27; i++) begin
      iv = vecs[i].in_v;
      {cmd_valid, abort, v_md, v_rv, v_wr, v_fd, v_af} = iv;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_outs", i), int'(outs()), int'(vecs[i].exp_o));
      chk($sformatf("vec%0d_row", i), int'(row_idx), int'(vecs[i].exp_row));
    end
    {cmd_valid, abort, v_md, v_rv, v_wr, v_fd, v_af} = '0;
    auto_m = 1'b1;
    @(posedge clk); #1;

    // Zero-latency SRAM full fill
    rd_delay = 0;
    clear_mon();
    run_to_done(400, k, got);
    chk("t1_done_seen", int'(got), 1);
    chk("t1_latency", k, 2 + NUM_ROWS * 4);
    chk("t1_row_idx", int'(row_idx), NUM_ROWS);
    @(posedge clk); #1;
    chk("t1_fill_pulses", fs_cnt, NUM_ROWS);
    chk("t1_fill_wide", fs_bad, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_idle", int'({cmd_ready, busy}), int'(2'b10));

    // Read data delayed 5 cycles every row
    rd_delay = 5;
    clear_mon();
    run_to_done(1000, k, got);
    chk("t2_latency", k, 2 + NUM_ROWS * 9);
    @(posedge clk); #1;
    chk("t2_row_runs", rs_n, NUM_ROWS);
    chk("t2_row_run_len", rs_bad, 0);
    chk("t2_fill_pulses", fs_cnt, NUM_ROWS);
    chk("t2_fill_wide", fs_bad, 0);

    // Abort in row 10 READ
    rd_delay = 3;
    clear_mon();
    cmd_valid = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 1000) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k++;
      if (row_start && row_idx == 7'd10) got = 1'b1;
    end
    chk("t3_reached_row10", int'(got), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t3_outs", int'(outs()), int'(7'b1000000));
    chk("t3_row_idx", int'(row_idx), 10);
    repeat (3) @(posedge clk); #1;
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_err_cnt", err_cnt, 0);

    // fill_done missing at row 3
    rd_delay = 0; fd_fault = 1'b1;
    clear_mon();
    cmd_valid = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 200) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k++;
      if (err) got = 1'b1;
    end
    chk("t4_err_seen", int'(got), 1);
    chk("t4_idle", int'({cmd_ready, busy}), int'(2'b10));
    chk("t4_row_idx", int'(row_idx), 3);
    fd_fault = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_err_cnt", err_cnt, 1);

    // wr_ready stuck low
    wr_stuck = 1'b1;
    clear_mon();
    cmd_valid = 1'b1;
`ifdef FILL_TIMEOUT_EN
    k = 0; got = 1'b0;
    while (!got && k < 400) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k++;
      if (err) got = 1'b1;
    end
    chk("t5_err_seen", int'(got), 1);
    chk("t5_err_edge", k, 3 + TIMEOUT_CYCLES + 1);
    chk("t5_idle", int'({cmd_ready, busy}), int'(2'b10));
`else
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("t5_stuck_wait", int'(outs()), int'(7'b0000100));
    chk("t5_err_cnt", err_cnt, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_idle", int'(outs()), int'(7'b1000000));
`endif
    wr_stuck = 1'b0;

    // Asynchronous reset during FILL
    clear_mon();
    cmd_valid = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 50) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k++;
      if (fill_start) got = 1'b1;
    end
    chk("t6_in_fill", int'(got), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_outs", int'(outs() & 7'b0111111), 0);
    chk("t6_rst_row", int'(row_idx), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_release", int'({cmd_ready, busy}), int'(2'b10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
